// File: rtl/fp16_acc_seq.sv
// Sequential FP16 accumulator around an external combinational fp16_add.
// Optional `FP16_ACC_SUBNORM_FLUSH_EN flushes subnormal inputs to signed zero.
module fp16_acc_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic [15:0]      add_c,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic             first;
    logic [15:0]      x;
    logic             beat;

    always_comb begin
        x = in_data;
`ifdef FP16_ACC_SUBNORM_FLUSH_EN
        if (in_data[14:10] == 5'd0 && in_data[9:0] != 10'd0) begin
            x = {in_data[15], 15'd0};
        end
`endif
    end

    assign beat     = (state == ACC) && in_valid && in_ready;
    assign add_a    = acc;
    assign add_b    = x;
    assign out_data = acc;

    // The adder assumes a hidden 1, so zero operands are handled here instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            cnt       <= '0;
            first     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= len;
                        acc   <= 16'h0000;
                        first <= 1'b1;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ACC;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        if (first || acc[14:0] == 15'd0) begin
                            acc <= x;
                        end else if (x[14:0] != 15'd0) begin
                            acc <= add_c;
                        end
                        first <= 1'b0;
                        cnt   <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
